// File: rtl/pkg_ula_controle.sv
// Shared definitions for the ALU sequencing counter: state encoding and default width.
package pkg_ula_controle;

    localparam int WIDTH_DEFAULT = 3;

    // 2'b11 is unused; the counter's next-state logic steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIM  = 2'b10
    } estado_t;

endpackage

// File: rtl/decrementador_nbits.sv
// Combinational ripple-borrow decrementer with a terminal-count (q == 1) flag.
module decrementador_nbits #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] d,
    output logic             is_one
);

    logic [WIDTH-1:0] borrow;

    assign borrow[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_diff
            assign d[i] = q[i] ^ borrow[i];
        end
        for (i = 0; i < WIDTH - 1; i++) begin : g_borrow
            assign borrow[i+1] = ~q[i] & borrow[i];
        end
    endgenerate

    assign is_one = (q == WIDTH'(1));

endmodule

// File: rtl/contador_regressivo.sv
// Loadable down-counter with start/busy/done handshake for iterative ALU operations.
//
// state | meaning
// IDLE  | waiting for start, Q held at 0
// RUN   | counting enabled cycles down towards zero
// FIM   | single-cycle done pulse; a start here begins the next run immediately
module contador_regressivo
    import pkg_ula_controle::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_dec;
    logic             cnt_is_one;

    decrementador_nbits #(.WIDTH(WIDTH)) u_dec (
        .q      (cnt_q),
        .d      (cnt_dec),
        .is_one (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        case (estado_q)
            IDLE, FIM: begin
                if (start) begin
                    cnt_d    = load_val;
                    estado_d = (load_val != '0) ? RUN : FIM;
                end else if (estado_q == FIM) begin
                    cnt_d    = '0;
                    estado_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_d    = '0;
                    estado_d = IDLE;
                end else if (enable) begin
                    // RUN exits on 1->0, so the decrement never wraps below zero.
                    if (cnt_is_one) begin
                        cnt_d    = '0;
                        estado_d = FIM;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
            end
            default: begin
                cnt_d    = '0;
                estado_d = IDLE;
            end
        endcase
    end

    assign Q    = cnt_q;
    assign busy = (estado_q == RUN);
    assign done = (estado_q == FIM);
    assign zero = (cnt_q == '0);

endmodule

// File: tb/tb_contador_regressivo.sv
// Directed table-driven bench for contador_regressivo plus hand-written multi-cycle sequences.
module tb_contador_regressivo;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] load_val;
    logic       enable;
    logic       abort;
    logic [2:0] Q;
    logic       busy;
    logic       done;
    logic       zero;

    int n_vec;
    int n_err;

    typedef struct {
        logic       rst;
        logic       start;
        logic [2:0] lv;
        logic       en;
        logic       ab;
        logic [2:0] q;
        logic       b;
        logic       d;
        logic       z;
    } vec_t;

    vec_t vec_q[$];

    contador_regressivo #(.WIDTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .enable   (enable),
        .abort    (abort),
        .Q        (Q),
        .busy     (busy),
        .done     (done),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic v(input logic r, input logic s, input logic [2:0] lv, input logic en,
                     input logic ab, input logic [2:0] q, input logic b, input logic d,
                     input logic z);
        vec_t t;
        t.rst = r; t.start = s; t.lv = lv; t.en = en; t.ab = ab;
        t.q = q; t.b = b; t.d = d; t.z = z;
        vec_q.push_back(t);
    endtask

    task automatic check(input string name, input logic [2:0] eq, input logic eb,
                         input logic ed, input logic ez);
        n_vec++;
        if (Q !== eq || busy !== eb || done !== ed || zero !== ez) begin
            n_err++;
            $display("FAIL %s: got Q=%0d busy=%b done=%b zero=%b, expected Q=%0d busy=%b done=%b zero=%b",
                     name, Q, busy, done, zero, eq, eb, ed, ez);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic s, input logic [2:0] lv,
                        input logic en, input logic ab);
        @(negedge clk);
        rst = r; start = s; load_val = lv; enable = en; abort = ab;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; load_val = 3'd0; enable = 1'b0; abort = 1'b0;

        //  rst st lv  en ab   q  b  d  z
        v(1, 0, 0, 0, 0,  0, 0, 0, 1);   // reset
        v(1, 1, 5, 1, 0,  0, 0, 0, 1);   // reset overrides start
        // run of 5, always enabled
        v(0, 1, 5, 1, 0,  5, 1, 0, 0);
        v(0, 0, 0, 1, 0,  4, 1, 0, 0);
        v(0, 0, 0, 1, 0,  3, 1, 0, 0);
        v(0, 0, 0, 1, 0,  2, 1, 0, 0);
        v(0, 0, 0, 1, 0,  1, 1, 0, 0);
        v(0, 0, 0, 1, 0,  0, 0, 1, 1);
        v(0, 0, 0, 1, 0,  0, 0, 0, 1);
        // zero load: straight to FIM, then again back-to-back from FIM
        v(0, 1, 0, 1, 0,  0, 0, 1, 1);
        v(0, 1, 0, 0, 0,  0, 0, 1, 1);
        v(0, 0, 0, 0, 0,  0, 0, 0, 1);
        // load 7 with two stalled cycles
        v(0, 1, 7, 1, 0,  7, 1, 0, 0);
        v(0, 0, 0, 1, 0,  6, 1, 0, 0);
        v(0, 0, 0, 0, 0,  6, 1, 0, 0);
        v(0, 0, 0, 0, 0,  6, 1, 0, 0);
        v(0, 0, 0, 1, 0,  5, 1, 0, 0);
        v(0, 0, 0, 1, 0,  4, 1, 0, 0);
        v(0, 0, 0, 1, 0,  3, 1, 0, 0);
        v(0, 0, 0, 1, 0,  2, 1, 0, 0);
        v(0, 0, 0, 1, 0,  1, 1, 0, 0);
        v(0, 0, 0, 1, 0,  0, 0, 1, 1);
        v(0, 0, 0, 0, 0,  0, 0, 0, 1);
        // load 6, start ignored mid-run, abort beats enable at Q=3
        v(0, 1, 6, 1, 0,  6, 1, 0, 0);
        v(0, 0, 0, 1, 0,  5, 1, 0, 0);
        v(0, 0, 0, 1, 0,  4, 1, 0, 0);
        v(0, 1, 7, 1, 0,  3, 1, 0, 0);
        v(0, 0, 0, 1, 1,  0, 0, 0, 1);
        v(0, 0, 0, 1, 0,  0, 0, 0, 1);
        // abort alongside start in IDLE: start wins
        v(0, 1, 1, 0, 1,  1, 1, 0, 0);
        v(0, 0, 0, 0, 0,  1, 1, 0, 0);
        v(0, 0, 0, 1, 0,  0, 0, 1, 1);
        // abort in FIM ignored, start accepted
        v(0, 1, 1, 1, 1,  1, 1, 0, 0);
        v(0, 0, 0, 1, 0,  0, 0, 1, 1);
        v(0, 0, 0, 1, 1,  0, 0, 0, 1);
        v(0, 0, 0, 1, 1,  0, 0, 0, 1);

        for (int i = 0; i < vec_q.size(); i++) begin
            step(vec_q[i].rst, vec_q[i].start, vec_q[i].lv, vec_q[i].en, vec_q[i].ab);
            check($sformatf("vec%0d", i), vec_q[i].q, vec_q[i].b, vec_q[i].d, vec_q[i].z);
        end

        // Back-to-back: run of 3, restart with 2 during its FIM cycle
        step(0, 1, 3'd3, 1, 0); check("b2b_load3", 3'd3, 1, 0, 0);
        step(0, 0, 3'd0, 1, 0); check("b2b_q2",    3'd2, 1, 0, 0);
        step(0, 0, 3'd0, 1, 0); check("b2b_q1",    3'd1, 1, 0, 0);
        step(0, 0, 3'd0, 1, 0); check("b2b_fim1",  3'd0, 0, 1, 1);
        step(0, 1, 3'd2, 1, 0); check("b2b_load2", 3'd2, 1, 0, 0);
        step(0, 0, 3'd0, 1, 0); check("b2b_q1b",   3'd1, 1, 0, 0);
        step(0, 0, 3'd0, 1, 0); check("b2b_fim2",  3'd0, 0, 1, 1);
        step(0, 0, 3'd0, 1, 0); check("b2b_idle",  3'd0, 0, 0, 1);

        // Reset mid-run at Q=4, then held with start asserted
        step(0, 1, 3'd7, 1, 0); check("rst_load7", 3'd7, 1, 0, 0);
        step(0, 0, 3'd0, 1, 0); check("rst_q6",    3'd6, 1, 0, 0);
        step(0, 0, 3'd0, 1, 0); check("rst_q5",    3'd5, 1, 0, 0);
        step(0, 0, 3'd0, 1, 0); check("rst_q4",    3'd4, 1, 0, 0);
        step(1, 0, 3'd0, 1, 0); check("rst_mid",   3'd0, 0, 0, 1);
        step(1, 1, 3'd5, 1, 0); check("rst_hold",  3'd0, 0, 0, 1);
        step(0, 0, 3'd0, 1, 0); check("rst_after", 3'd0, 0, 0, 1);
        step(0, 0, 3'd0, 1, 0); check("rst_nodone",3'd0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
